// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative multiply/divide unit with the HI/LO register pair, fed from the
// ID/EX pipeline register. MULT/MULTU/DIV/DIVU take one cycle to latch the
// operands, DATA_W cycles of shift-add or shift-subtract iteration, and one
// cycle of sign fix-up. MTHI/MTLO write HI/LO in a single cycle.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   md_valid    ID/EX holds a valid instruction this cycle
//   funct       funct field from ID/EX
//   data_read1  rs operand
//   data_read2  rt operand
//   flush       abort an in-flight operation / squash the current instruction
//   busy        operation in flight, upstream stalls ID/EX
//   done        one-cycle pulse after HI/LO were written by a mult/div
//   hi_out      HI register
//   lo_out      LO register
//   mf_data     HI when funct selects MFHI, otherwise LO
module ex_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              md_valid,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] data_read1,
    input  logic [DATA_W-1:0] data_read2,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [DATA_W-1:0] mf_data
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_lo;     // negate product (mult) or quotient (div)
    logic               r_neg_hi;     // negate remainder (div)
    logic [DATA_W-1:0]  r_acc;        // product high half / partial remainder
    logic [DATA_W-1:0]  r_q;          // multiplier shifting out / quotient shifting in
    logic [DATA_W-1:0]  r_b;          // multiplicand / divisor magnitude
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic               r_done;

    // Decode
    logic               w_is_md;
    logic               w_start;
    logic               w_signed;
    logic               w_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_div0;
    logic [DATA_W-1:0]  w_a_mag;
    logic [DATA_W-1:0]  w_b_mag;

    // Iteration datapath
    logic [DATA_W:0]    w_mul_sum;
    logic [DATA_W:0]    w_div_shift;
    logic               w_div_ge;
    logic [DATA_W-1:0]  w_div_diff;

    // Fix-up
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    always_comb begin
        w_is_md  = (funct[5:2] == 4'b0110);          // 0x18..0x1B
        w_start  = md_valid && !flush && w_is_md;
        w_signed = !funct[0];
        w_div    = funct[1];
        w_a_neg  = w_signed && data_read1[DATA_W-1];
        w_b_neg  = w_signed && data_read2[DATA_W-1];
        w_div0   = w_div && (data_read2 == '0);
        w_a_mag  = w_a_neg ? -data_read1 : data_read1;
        w_b_mag  = w_b_neg ? -data_read2 : data_read2;

        w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
        w_div_shift = {r_acc, r_q[DATA_W-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        // The partial remainder stays below the divisor, so when the trial
        // subtract succeeds the difference fits DATA_W bits.
        w_div_diff  = w_div_shift[DATA_W-1:0] - r_b;

        w_prod     = {r_acc, r_q};
        w_prod_fix = r_neg_lo ? -w_prod : w_prod;
        w_quo_fix  = r_neg_lo ? -r_q : r_q;
        w_rem_fix  = r_neg_hi ? -r_acc : r_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= CALC;
                        r_cnt    <= '0;
                        r_is_div <= w_div;
                        r_acc    <= '0;
                        // Divide by zero runs the raw operands through an
                        // unsigned divide by 0: quotient becomes all ones and
                        // the remainder ends up equal to rs, untouched.
                        r_q      <= w_div0 ? data_read1 : w_a_mag;
                        r_b      <= w_div0 ? '0 : w_b_mag;
                        r_neg_lo <= !w_div0 && (w_a_neg ^ w_b_neg);
                        r_neg_hi <= !w_div0 && (w_div ? w_a_neg : (w_a_neg ^ w_b_neg));
                    end else if (md_valid && !flush && funct == 6'h11) begin
                        r_hi <= data_read1;
                    end else if (md_valid && !flush && funct == 6'h13) begin
                        r_lo <= data_read1;
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_acc <= w_div_ge ? w_div_diff : w_div_shift[DATA_W-1:0];
                            r_q   <= {r_q[DATA_W-2:0], w_div_ge};
                        end else begin
                            r_acc <= w_mul_sum[DATA_W:1];
                            r_q   <= {w_mul_sum[0], r_q[DATA_W-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ITER) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod_fix[DATA_W-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign hi_out  = r_hi;
    assign lo_out  = r_lo;
    assign mf_data = (funct == 6'h10) ? r_hi : r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, hand-written
// flush/reset/MTHI/MTLO sequences, and random mult/div against a 64-bit
// arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_valid;
    logic [5:0]  funct;
    logic [31:0] data_read1;
    logic [31:0] data_read2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mf_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_valid   (md_valid),
        .funct      (funct),
        .data_read1 (data_read1),
        .data_read2 (data_read2),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .mf_data    (mf_data)
    );

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            6'h18: return 64'(sa * sb);
            6'h19: return ua * ub;
            6'h1A: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Issue one mult/div and check latency, done pulse and HI/LO.
    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        int cyc;
        @(negedge clk);
        md_valid   = 1'b1;
        funct      = f;
        data_read1 = a;
        data_read2 = b;
        @(negedge clk);
        md_valid = 1'b0;
        funct    = 6'h00;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({nm, " busy_cycles"}, 64'(cyc), 64'd33);
        check({nm, " done"}, {63'd0, done}, 64'd1);
        check({nm, " hi"}, {32'd0, hi_out}, {32'd0, ehi});
        check({nm, " lo"}, {32'd0, lo_out}, {32'd0, elo});
        $display("op %s f=%h a=%h b=%h -> hi=%h lo=%h cycles=%0d", nm, f, a, b,
                 hi_out, lo_out, cyc);
        @(negedge clk);
        check({nm, " done_pulse_end"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] ref_v;
        logic [31:0] old_hi, old_lo;
        logic [5:0]  rf;
        logic [31:0] ra, rb;
        int          seen_done;

        vecs[0] = '{6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{6'h18, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{6'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{6'h1B, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[5] = '{6'h1A, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF};

        rst_n = 1'b0; md_valid = 1'b1; funct = 6'h18;
        data_read1 = 32'd5; data_read2 = 32'd6; flush = 1'b0;

        // Reset held two cycles while a MULT is presented.
        @(negedge clk);
        @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi_out}, 64'd0);
        check("reset lo", {32'd0, lo_out}, 64'd0);
        rst_n = 1'b1; md_valid = 1'b0;
        @(negedge clk);
        check("post reset no start", {63'd0, busy}, 64'd0);
        $display("op reset released busy=%0d", busy);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_md(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo,
                   $sformatf("vec%0d", i));
        end

        // MTHI then MTLO on consecutive cycles.
        @(negedge clk);
        md_valid = 1'b1; funct = 6'h11; data_read1 = 32'h1234_5678;
        @(negedge clk);
        check("mthi hi", {32'd0, hi_out}, 64'h1234_5678);
        check("mthi busy", {63'd0, busy}, 64'd0);
        funct = 6'h13; data_read1 = 32'hCAFE_BABE;
        @(negedge clk);
        check("mtlo lo", {32'd0, lo_out}, 64'hCAFE_BABE);
        check("mtlo hi kept", {32'd0, hi_out}, 64'h1234_5678);
        check("mtlo busy", {63'd0, busy}, 64'd0);
        md_valid = 1'b0; funct = 6'h10;
        #1 check("mfhi data", {32'd0, mf_data}, 64'h1234_5678);
        funct = 6'h12;
        #1 check("mflo data", {32'd0, mf_data}, 64'hCAFE_BABE);
        $display("op mthi/mtlo hi=%h lo=%h", hi_out, lo_out);

        // Flush while idle suppresses a start and an MTHI.
        @(negedge clk);
        md_valid = 1'b1; funct = 6'h19; flush = 1'b1;
        @(negedge clk);
        check("idle flush no start", {63'd0, busy}, 64'd0);
        funct = 6'h11; data_read1 = 32'hDEAD_BEEF;
        @(negedge clk);
        check("idle flush no mthi", {32'd0, hi_out}, 64'h1234_5678);
        md_valid = 1'b0; flush = 1'b0;
        $display("op idle flush hi=%h busy=%0d", hi_out, busy);

        // Flush mid-divide, then immediate restart.
        old_hi = hi_out; old_lo = lo_out;
        @(negedge clk);
        md_valid = 1'b1; funct = 6'h1B; data_read1 = 32'd1000; data_read2 = 32'd7;
        @(negedge clk);
        md_valid = 1'b0; funct = 6'h00;
        repeat (9) @(negedge clk);
        check("flush pre busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy drop", {63'd0, busy}, 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check("flush no done", 64'(seen_done), 64'd0);
        check("flush hi kept", {32'd0, hi_out}, {32'd0, old_hi});
        check("flush lo kept", {32'd0, lo_out}, {32'd0, old_lo});
        $display("op flush divu hi=%h lo=%h", hi_out, lo_out);
        run_md(6'h19, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 32'h000B_000F, "restart");

        // Reset mid-multiply discards everything.
        @(negedge clk);
        md_valid = 1'b1; funct = 6'h19; data_read1 = 32'd77; data_read2 = 32'd99;
        @(negedge clk);
        md_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset hi", {32'd0, hi_out}, 64'd0);
        check("midreset lo", {32'd0, lo_out}, 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check("midreset no done", 64'(seen_done), 64'd0);
        $display("op midreset busy=%0d hi=%h lo=%h", busy, hi_out, lo_out);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rf = 6'h18 + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            ref_v = model(rf, ra, rb);
            run_md(rf, ra, rb, ref_v[63:32], ref_v[31:0], $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EX pipeline register outputs: operands (rs, rt) and funct.
- Implements iterative MULT/MULTU/DIV/DIVU and the HI/LO register pair.
- Also implements MTHI/MTLO and provides read data for MFHI/MFLO.
- Drives busy back upstream so the hazard logic holds the ID/EX register while an operation is in flight.

Parameters:
DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
md_valid  input  1  ID/EX slot holds a valid instruction this cycle
funct  input  6  funct field from ID/EX
data_read1  input  DATA_W  rs operand from ID/EX
data_read2  input  DATA_W  rt operand from ID/EX
flush  input  1  abort in-flight operation (branch/exception squash)
busy  output  1  operation in flight; upstream must stall ID/EX
done  output  1  one-cycle pulse when HI/LO updated by mult/div
hi_out  output  DATA_W  HI register
lo_out  output  DATA_W  LO register
mf_data  output  DATA_W  combinational: hi_out when funct=0x10, else lo_out

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; hi_out=0, lo_out=0, busy=0, done=0; counter and datapath cleared. Reset overrides flush and start.
- Decode, only when md_valid=1 and state=IDLE:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU -> start.
  - 0x11 MTHI: hi_out<=data_read1 at the next edge. 0x13 MTLO: lo_out<=data_read1 at the next edge. Single cycle, busy stays 0.
  - Any other funct is ignored.
- md_valid while busy=1 is ignored; upstream stall is the guarantee.
- States: IDLE -> CALC -> FIX -> IDLE.
  - IDLE, start sampled at edge T: latch operands. For signed ops, store absolute values and result signs. Counter=0, go CALC.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle at edges T+1..T+32. After the 32nd iteration, go FIX.
  - FIX, edge T+33: apply sign correction and write HI/LO.
    - Mult: HI=upper 32 bits, LO=lower 32 bits.
    - Div: LO=quotient, HI=remainder; remainder sign follows the dividend.
    - Go IDLE.
- Timing: busy=(state!=IDLE), so it is high for 33 cycles, from after edge T through edge T+33. done=1 for exactly the cycle after edge T+33.
- Back-to-back: a new start can be accepted at edge T+34, the first cycle with busy=0.
- Width rules:
  - Unsigned magnitudes are handled with a 33-bit internal path.
  - Signed mult negates the 64-bit product when the operand signs differ.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. No trap.
- Divide by zero (rt=0), signed or unsigned: LO=0xFFFFFFFF, HI=rs unchanged. Same 33-cycle latency, no sign fix, no trap.
- flush=1 at any edge while CALC/FIX: return to IDLE. HI/LO keep their prior values, done is not pulsed, busy=0 the next cycle.
- flush=1 while IDLE: suppresses a start or MTHI/MTLO presented in the same cycle.
- Reset mid-operation: identical to the reset values above, and any partial result is discarded.
- mf_data is purely combinational from the HI/LO registers. An MFHI/MFLO in the cycle after done reads the new values.

Test Plan:
- Reset: hold rst_n=0 two cycles with md_valid=1 and funct=0x18 -> busy=0, done=0, hi_out=lo_out=0. No start after reset is released unless md_valid is re-presented.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF at edge T -> busy high 33 cycles, done at T+34 cycle, HI=0xFFFFFFFE, LO=0x00000001.
- MULT -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> after 33 busy cycles, LO=0xFFFFFFFF, HI=100, done pulses.
- MTHI 0x12345678 then MTLO 0xCAFEBABE on consecutive cycles -> hi_out/lo_out update one edge later, busy stays 0. mf_data follows funct 0x10/0x12.
- Start DIVU, assert flush at cycle 10 -> busy drops next cycle, no done, HI/LO unchanged. An immediate MULTU restart gives the correct result.
